tl_ul_reg_responder: RTL and testbench
======================================

// Module: tl_ul_reg_responder
// PURPOSE
//  TileLink-UL manager (responder) terminating the A channel of a bus-bypass bar's real output port.
//  - Serves 32-bit Get/PutFullData to a small word register bank.
//  - Returns denied responses for anything it cannot serve; never hangs the bus.
//  - One response buffer: 1-cycle latency, full throughput when d_ready is held high.
// PARAMETERS
//  NUM_REGS   16            number of 32-bit word registers (2..128), indexed by a_address[8:2]
//  ID_VALUE   32'h544C_5231 read-only contents of register 0
// PORTS
//  clock                   in   1   sole clock; all state on rising edge
//  reset                   in   1   synchronous, active-high
//  auto_in_a_ready         out  1   A channel ready
//  auto_in_a_valid         in   1   A channel valid
//  auto_in_a_bits_opcode   in   3   0=PutFullData, 4=Get; others unsupported
//  auto_in_a_bits_size     in   2   log2 bytes; only 2 supported
//  auto_in_a_bits_source   in   1   requester id, echoed on D
//  auto_in_a_bits_address  in   9   byte address
//  auto_in_a_bits_data     in   32  write data
//  auto_in_d_ready         in   1   D channel ready
//  auto_in_d_valid         out  1   D channel valid
//  auto_in_d_bits_opcode   out  3   0=AccessAck, 1=AccessAckData
//  auto_in_d_bits_param    out  2   always 0
//  auto_in_d_bits_size     out  2   echo of captured a_size
//  auto_in_d_bits_source   out  1   echo of captured a_source
//  auto_in_d_bits_sink     out  1   always 0
//  auto_in_d_bits_denied   out  1   request rejected
//  auto_in_d_bits_data     out  32  read data; 0 when denied or AccessAck
//  auto_in_d_bits_corrupt  out  1   = denied on AccessAckData, else 0
// BEHAVIOUR
//  Reset: d_valid=0, all D bits=0, regs[1..NUM_REGS-1]=0, state=IDLE.
//   - a_ready=0 while reset is high.
//   - Reset asserted with a response pending discards it; no D beat follows.
//  FSM (single response buffer):
//   - IDLE: d_valid=0, a_ready=1. A fire -> RESP.
//   - RESP: d_valid=1, a_ready=d_ready.
//   - RESP with D fire and A fire in the same cycle -> stay RESP, buffer reloaded (back-to-back).
//   - RESP with D fire and no A fire -> IDLE.
//   - RESP without D fire: all D bits held stable; no A accepted.
//  Latency: A fire in cycle N -> d_valid=1 in cycle N+1.
//  Decode on A fire, idx = address[8:2]. Denied when any of:
//   - address[1:0]!=0
//   - size!=2
//   - idx>=NUM_REGS
//   - opcode not in {0,4}
//   - Put to idx 0
//  Get:
//   - d_opcode=1.
//   - data = idx0 ? ID_VALUE : regs[idx], sampled at A fire.
//   - Read of a reg being written in the same cycle returns the old value.
//  PutFullData:
//   - d_opcode=0.
//   - regs[idx]<=data at A fire, only if not denied.
//  Denied:
//   - Get or opcode 1..3 -> opcode AccessAckData (1) for Get, else AccessAck (0).
//   - denied=1; corrupt=1 only for AccessAckData; data=0; no state change.
//  No combinational path a_valid->d_valid. a_ready depends only on state and d_ready.
// TESTING
//  1. Reset, Put addr 0x08 data 0xDEADBEEF src1, then Get 0x08 -> AccessAck src1 den0;
//     AccessAckData data 0xDEADBEEF den0 cor0.
//  2. Get 0x00 -> data 0x544C5231. Put 0x00 -> AccessAck denied=1; reg0 unchanged.
//  3. Get 0x40 (idx16), Get 0x09, Get size 1 -> each AccessAckData denied=1 corrupt=1 data 0.
//  4. d_ready=1, 8 back-to-back Puts -> a_ready stays 1, one D per cycle, each 1 cycle after its A.
//  5. d_ready=0 for 5 cycles with response pending -> a_ready=0, D bits stable;
//     release -> single D fire.
//  6. Reset asserted while d_valid=1 -> next cycle d_valid=0, regs cleared, no stale D.

Source files
------------

// File: rtl/tl_ul_reg_responder_if.sv
// TileLink-UL A/D channel bundle between a requester (master) and the register responder (slave).
interface tl_ul_reg_responder_if;
  logic        auto_in_a_ready;
  logic        auto_in_a_valid;
  logic [2:0]  auto_in_a_bits_opcode;
  logic [1:0]  auto_in_a_bits_size;
  logic        auto_in_a_bits_source;
  logic [8:0]  auto_in_a_bits_address;
  logic [31:0] auto_in_a_bits_data;
  logic        auto_in_d_ready;
  logic        auto_in_d_valid;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_param;
  logic [1:0]  auto_in_d_bits_size;
  logic        auto_in_d_bits_source;
  logic        auto_in_d_bits_sink;
  logic        auto_in_d_bits_denied;
  logic [31:0] auto_in_d_bits_data;
  logic        auto_in_d_bits_corrupt;

  modport slave (
    output auto_in_a_ready,
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
    input  auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_data,
    input  auto_in_d_ready,
    output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
    output auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
    output auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt
  );

  modport master (
    input  auto_in_a_ready,
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
    output auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_data,
    output auto_in_d_ready,
    input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
    input  auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
    input  auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt
  );
endinterface

// File: rtl/tl_ul_reg_responder.sv
// TileLink-UL register responder: 32-bit Get/PutFullData on a word bank, denies everything else.
// Single response buffer: D valid one cycle after A fire; A is held off only while a response waits on d_ready.
module tl_ul_reg_responder #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h544C_5231
) (
  input logic                  clock,
  input logic                  reset,
  tl_ul_reg_responder_if.slave tl
);
  localparam logic [2:0] A_PUT_FULL = 3'd0;
  localparam logic [2:0] A_GET      = 3'd4;
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;

  typedef enum logic {IDLE, RESP} state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic        source;
    logic        denied;
    logic [31:0] data;
  } d_bits_t;

  state_t      state_q, state_d;
  d_bits_t     d_q, d_d;
  logic [31:0] regs_q [1:NUM_REGS-1];

  logic        a_rdy, a_fire, d_vld, d_fire;
  logic [6:0]  idx;
  logic        is_get, is_put, denied, wr_en;
  logic [31:0] rd_word;

  // a_ready is a function of state and d_ready only, so A never waits on itself.
  assign a_rdy  = !reset && ((state_q == IDLE) || tl.auto_in_d_ready);
  assign d_vld  = (state_q == RESP);
  assign a_fire = tl.auto_in_a_valid && a_rdy;
  assign d_fire = d_vld && tl.auto_in_d_ready;

  assign idx    = tl.auto_in_a_bits_address[8:2];
  assign is_get = (tl.auto_in_a_bits_opcode == A_GET);
  assign is_put = (tl.auto_in_a_bits_opcode == A_PUT_FULL);
  assign denied = (tl.auto_in_a_bits_address[1:0] != 2'b00)
               || (tl.auto_in_a_bits_size != 2'd2)
               || (int'(idx) >= NUM_REGS)
               || !(is_get || is_put)
               || (is_put && (idx == 7'd0));
  assign wr_en  = a_fire && is_put && !denied;

  // Register 0 is the read-only ID; the bank itself starts at index 1.
  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == 7'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    d_d        = '0;
    d_d.opcode = is_get ? D_ACK_DATA : D_ACK;
    d_d.size   = tl.auto_in_a_bits_size;
    d_d.source = tl.auto_in_a_bits_source;
    d_d.denied = denied;
    d_d.data   = (is_get && !denied) ? rd_word : 32'd0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_fire) state_d = RESP;
      RESP:    if (d_fire && !a_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (a_fire) d_q <= d_d;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && (idx == 7'(i))) regs_q[i] <= tl.auto_in_a_bits_data;
      end
    end
  end

  assign tl.auto_in_a_ready        = a_rdy;
  assign tl.auto_in_d_valid        = d_vld;
  assign tl.auto_in_d_bits_opcode  = d_q.opcode;
  assign tl.auto_in_d_bits_param   = 2'd0;
  assign tl.auto_in_d_bits_size    = d_q.size;
  assign tl.auto_in_d_bits_source  = d_q.source;
  assign tl.auto_in_d_bits_sink    = 1'b0;
  assign tl.auto_in_d_bits_denied  = d_q.denied;
  assign tl.auto_in_d_bits_data    = d_q.data;
  assign tl.auto_in_d_bits_corrupt = d_q.denied && (d_q.opcode == D_ACK_DATA);
endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// Bench for tl_ul_reg_responder: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_tl_ul_reg_responder;
  localparam logic [31:0] ID = 32'h544C_5231;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [1:0]  size;
    logic        source;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tl_ul_reg_responder_if bus ();

  tl_ul_reg_responder #(.NUM_REGS(16), .ID_VALUE(ID)) dut (
    .clock (clock),
    .reset (reset),
    .tl    (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mregs [16];
  beat_t       exp_q [$];
  beat_t       got_q [$];
  bit          pending  = 0;
  bit          started  = 0;
  bit          rand_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got op=%0d sz=%0d src=%0d den=%0d cor=%0d data=%h par=%0d snk=%0d expected op=%0d sz=%0d src=%0d den=%0d cor=%0d data=%h (t=%0t)",
               nm, act.opcode, act.size, act.source, act.denied, act.corrupt, act.data, act.param, act.sink,
               exp.opcode, exp.size, exp.source, exp.denied, exp.corrupt, exp.data, $time);
    end
  endtask

  function automatic beat_t actual_beat();
    beat_t b;
    b.opcode  = bus.auto_in_d_bits_opcode;
    b.param   = bus.auto_in_d_bits_param;
    b.size    = bus.auto_in_d_bits_size;
    b.source  = bus.auto_in_d_bits_source;
    b.sink    = bus.auto_in_d_bits_sink;
    b.denied  = bus.auto_in_d_bits_denied;
    b.data    = bus.auto_in_d_bits_data;
    b.corrupt = bus.auto_in_d_bits_corrupt;
    return b;
  endfunction

  function automatic beat_t mk(input logic [2:0] op, input logic [1:0] sz, input logic src,
                               input logic den, input logic cor, input logic [31:0] dat);
    beat_t b = '0;
    b.opcode = op; b.size = sz; b.source = src; b.denied = den; b.corrupt = cor; b.data = dat;
    return b;
  endfunction

  // Transaction-level meaning of one accepted request; also applies its register side effect.
  function automatic beat_t model_access(input logic [2:0] op, input logic [1:0] sz, input logic src,
                                         input logic [8:0] addr, input logic [31:0] wd);
    int    idx = int'(addr[8:2]);
    bit    get = (op == 3'd4);
    bit    put = (op == 3'd0);
    bit    ok  = (addr[1:0] == 2'b00) && (sz == 2'd2) && (idx < 16) && (get || (put && idx != 0));
    logic [31:0] rd = 32'd0;
    if (get && ok) rd = (idx == 0) ? ID : mregs[idx];
    if (put && ok) mregs[idx] = wd;
    return mk(get ? 3'd1 : 3'd0, sz, src, !ok, get && !ok, rd);
  endfunction

  // Compare on the falling edge, then advance the model by what the next rising edge will see.
  always @(negedge clock) begin : monitor
    bit exp_ardy, a_fire, d_fire;
    if (!started) begin
      if (reset === 1'b1) begin
        started = 1;
        pending = 0;
        exp_q.delete();
        foreach (mregs[i]) mregs[i] = 32'd0;
      end
    end else begin
      exp_ardy = !reset && (!pending || bus.auto_in_d_ready);
      chk("a_ready", 64'(bus.auto_in_a_ready), 64'(exp_ardy));
      chk("d_valid", 64'(bus.auto_in_d_valid), 64'(pending));
      if (pending) chk_beat("d_bits", actual_beat(), exp_q[0]);
      if (reset) begin
        pending = 0;
        exp_q.delete();
        foreach (mregs[i]) mregs[i] = 32'd0;
      end else begin
        a_fire = bus.auto_in_a_valid && exp_ardy;
        d_fire = pending && bus.auto_in_d_ready;
        if (d_fire) begin
          got_q.push_back(actual_beat());
          void'(exp_q.pop_front());
        end
        if (a_fire)
          exp_q.push_back(model_access(bus.auto_in_a_bits_opcode, bus.auto_in_a_bits_size,
                                       bus.auto_in_a_bits_source, bus.auto_in_a_bits_address,
                                       bus.auto_in_a_bits_data));
        pending = (pending && !d_fire) || a_fire;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic src, input logic [8:0] addr,
                      input logic [31:0] wd, input bit hold, output int waited);
    bit acc;
    waited = 0;
    bus.auto_in_a_valid        = 1'b1;
    bus.auto_in_a_bits_opcode  = op;
    bus.auto_in_a_bits_size    = sz;
    bus.auto_in_a_bits_source  = src;
    bus.auto_in_a_bits_address = addr;
    bus.auto_in_a_bits_data    = wd;
    do begin
      @(negedge clock); acc = bus.auto_in_a_ready;
      @(posedge clock); #1; waited++;
    end while (!acc && waited < 200);
    if (!acc) begin
      checks++; failures++;
      $display("FAIL a_accept: request op=%0d addr=%h not accepted within %0d cycles", op, addr, waited);
    end
    if (!hold) bus.auto_in_a_valid = 1'b0;
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] sz, input logic src,
                     input logic [8:0] addr, input logic [31:0] wd);
    int w;
    send(op, sz, src, addr, wd, 1'b0, w);
  endtask

  // back=0 is the most recent D beat, back=1 the one before, and so on.
  task automatic expect_beat(input string nm, input int back, input beat_t exp);
    if (got_q.size() <= back) begin
      checks++; failures++;
      $display("FAIL %s: only %0d D beats seen, expected at least %0d", nm, got_q.size(), back + 1);
    end else begin
      chk_beat(nm, got_q[got_q.size() - 1 - back], exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand_rdy) bus.auto_in_d_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w, tot, n0;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [8:0]  addr;
    bit          hold;

    reset = 1'b1;
    bus.auto_in_a_valid = 1'b0;
    bus.auto_in_a_bits_opcode = '0; bus.auto_in_a_bits_size = '0; bus.auto_in_a_bits_source = '0;
    bus.auto_in_a_bits_address = '0; bus.auto_in_a_bits_data = '0;
    bus.auto_in_d_ready = 1'b1;
    cyc(3);
    chk_beat("reset_d_bits", actual_beat(), '0);
    chk("reset_a_ready", 64'(bus.auto_in_a_ready), 64'd0);
    reset = 1'b0;
    cyc(1);

    req(3'd0, 2'd2, 1'b1, 9'h008, 32'hDEAD_BEEF);
    req(3'd4, 2'd2, 1'b1, 9'h008, 32'h0);
    cyc(1);
    expect_beat("t1_put_ack", 1, mk(3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0));
    expect_beat("t1_get_data", 0, mk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF));

    req(3'd4, 2'd2, 1'b0, 9'h000, 32'h0);
    req(3'd0, 2'd2, 1'b0, 9'h000, 32'h1234_5678);
    req(3'd4, 2'd2, 1'b0, 9'h000, 32'h0);
    cyc(1);
    expect_beat("t2_get_id", 2, mk(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, ID));
    expect_beat("t2_put_id_denied", 1, mk(3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0));
    expect_beat("t2_id_unchanged", 0, mk(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, ID));

    req(3'd4, 2'd2, 1'b0, 9'h040, 32'h0);
    req(3'd4, 2'd2, 1'b1, 9'h009, 32'h0);
    req(3'd4, 2'd1, 1'b0, 9'h008, 32'h0);
    req(3'd1, 2'd2, 1'b0, 9'h008, 32'h0BAD_0BAD);
    req(3'd5, 2'd2, 1'b1, 9'h008, 32'h0BAD_0BAD);
    req(3'd4, 2'd2, 1'b0, 9'h008, 32'h0);
    cyc(1);
    expect_beat("t3_idx16", 5, mk(3'd1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h0));
    expect_beat("t3_misaligned", 4, mk(3'd1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h0));
    expect_beat("t3_size1", 3, mk(3'd1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h0));
    expect_beat("t3_partial_put", 2, mk(3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0));
    expect_beat("t3_bad_opcode", 1, mk(3'd0, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0));
    expect_beat("t3_no_side_effect", 0, mk(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF));

    bus.auto_in_d_ready = 1'b1;
    n0 = got_q.size();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(3'd0, 2'd2, 1'(i), 9'((i + 1) * 4), 32'h1000_0000 + 32'(i), i < 7, w);
      tot += w;
    end
    cyc(2);
    chk("b2b_accept_cycles", 64'(tot), 64'd8);
    chk("b2b_beats", 64'(got_q.size() - n0), 64'd8);
    req(3'd4, 2'd2, 1'b0, 9'h020, 32'h0);
    cyc(1);
    expect_beat("b2b_readback", 0, mk(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h1000_0007));

    bus.auto_in_d_ready = 1'b0;
    req(3'd0, 2'd2, 1'b1, 9'h00C, 32'hCAFE_F00D);
    n0 = got_q.size();
    cyc(5);
    chk("stall_no_beat", 64'(got_q.size() - n0), 64'd0);
    chk("stall_a_ready", 64'(bus.auto_in_a_ready), 64'd0);
    chk("stall_d_valid", 64'(bus.auto_in_d_valid), 64'd1);
    bus.auto_in_d_ready = 1'b1;
    cyc(1);
    chk("stall_release_beat", 64'(got_q.size() - n0), 64'd1);
    cyc(1);
    chk("stall_single_beat", 64'(got_q.size() - n0), 64'd1);
    chk("stall_idle_after", 64'(bus.auto_in_d_valid), 64'd0);

    bus.auto_in_d_ready = 1'b0;
    req(3'd4, 2'd2, 1'b0, 9'h00C, 32'h0);
    n0 = got_q.size();
    reset = 1'b1;
    cyc(1);
    chk("rst_drop_d_valid", 64'(bus.auto_in_d_valid), 64'd0);
    chk_beat("rst_d_bits", actual_beat(), '0);
    bus.auto_in_d_ready = 1'b1;
    reset = 1'b0;
    cyc(2);
    chk("rst_no_stale_beat", 64'(got_q.size() - n0), 64'd0);
    req(3'd4, 2'd2, 1'b1, 9'h00C, 32'h0);
    req(3'd4, 2'd2, 1'b0, 9'h020, 32'h0);
    cyc(1);
    expect_beat("rst_cleared_c", 1, mk(3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0));
    expect_beat("rst_cleared_20", 0, mk(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0));

    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      op   = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0) : 3'($urandom_range(0, 7));
      sz   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      addr = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : {2'b00, 5'($urandom_range(0, 17)), 2'b00};
      hold = ($urandom_range(0, 1) != 0);
      send(op, sz, 1'($urandom_range(0, 1)), addr, $urandom, hold, w);
      if (!hold) cyc($urandom_range(0, 2));
    end
    bus.auto_in_a_valid = 1'b0;
    rand_rdy = 0;
    cyc(1);
    bus.auto_in_d_ready = 1'b1;
    cyc(4);
    chk("drain_d_valid", 64'(bus.auto_in_d_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
